// File: rtl/mips_pkg.sv
// Shared constants, command opcodes and FSM encoding for the MIPS debug unit.
package mips_pkg;

    localparam int unsigned LEN               = 32;
    localparam int unsigned NB_BYTE           = 8;
    localparam int unsigned BYTES_PER_WORD    = LEN / NB_BYTE;
    localparam int unsigned NB_BIDX           = $clog2(BYTES_PER_WORD);
    localparam int unsigned RAM_DEPTH_PROGRAM = 32;
    localparam int unsigned RAM_DEPTH_DATA    = 32;
    localparam int unsigned NB_PADDR          = 5;
    localparam int unsigned NB_DADDR          = 5;
    // Load word counter spans the full range of the count byte.
    localparam int unsigned NB_WIDX           = NB_BYTE;
    // Dump frame: PC word, cycle-count word, then every data memory word.
    localparam int unsigned DUMP_WORDS        = 2 + RAM_DEPTH_DATA;
    localparam int unsigned NB_DIDX           = $clog2(DUMP_WORDS);

    localparam logic [NB_BYTE-1:0] CMD_LOAD = 8'h4C;
    localparam logic [NB_BYTE-1:0] CMD_CONT = 8'h43;
    localparam logic [NB_BYTE-1:0] CMD_STEP = 8'h53;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_LOAD_CNT,
        ST_LOAD_BYTE,
        ST_LOAD_WR,
        ST_RUN,
        ST_STEP,
        ST_DUMP_LD,
        ST_DUMP_TX,
        ST_DUMP_WAIT
    } state_e;

endpackage

// File: rtl/debug_word_serializer.sv
// Holds one LEN-bit word and hands it to the UART transmitter MSB byte first.
module debug_word_serializer
    import mips_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_load,
    input  logic [LEN-1:0]     i_word,
    input  logic               i_send,
    output logic [NB_BYTE-1:0] o_tx_data,
    output logic               o_tx_start,
    output logic               o_done_c
);

    localparam int unsigned NB_SENT = NB_BIDX + 1;

    logic [LEN-1:0]     word_q, word_d;
    logic [NB_SENT-1:0] sent_q, sent_d;
    logic [NB_BYTE-1:0] tx_data_q, tx_data_d;
    logic               tx_start_q, tx_start_d;

    assign o_done_c   = (sent_q == NB_SENT'(BYTES_PER_WORD));
    assign o_tx_data  = tx_data_q;
    assign o_tx_start = tx_start_q;

    // Load a fresh word, or present the top byte with a one-cycle start strobe and shift.
    always_comb begin
        word_d     = word_q;
        sent_d     = sent_q;
        tx_data_d  = tx_data_q;
        tx_start_d = 1'b0;
        if (i_load) begin
            word_d = i_word;
            sent_d = '0;
        end else if (i_send && !o_done_c) begin
            tx_data_d  = word_q[LEN-1 -: NB_BYTE];
            tx_start_d = 1'b1;
            word_d     = {word_q[LEN-NB_BYTE-1:0], {NB_BYTE{1'b0}}};
            sent_d     = sent_q + NB_SENT'(1);
        end
    end

    // Serializer registers.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            word_q     <= '0;
            sent_q     <= '0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
        end else begin
            word_q     <= word_d;
            sent_q     <= sent_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
        end
    end

endmodule

// File: rtl/mips_debug_unit.sv
// Host-side debug controller: loads program memory, runs or steps the core, dumps state.
module mips_debug_unit
    import mips_pkg::*;
(
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [NB_BYTE-1:0]  i_rx_data,
    input  logic                i_rx_done,
    output logic [NB_BYTE-1:0]  o_tx_data,
    output logic                o_tx_start,
    input  logic                i_tx_done,
    output logic                o_prog_we,
    output logic [NB_PADDR-1:0] o_prog_addr,
    output logic [LEN-1:0]      o_prog_data,
    output logic                o_cpu_en,
    output logic                o_cpu_rst_n,
    input  logic                i_halt,
    input  logic [LEN-1:0]      i_pc,
    output logic [NB_DADDR-1:0] o_dmem_addr,
    input  logic [LEN-1:0]      i_dmem_data
);

    state_e              state_q, state_d;
    logic [NB_WIDX-1:0]  nwords_q, nwords_d;
    logic [NB_WIDX-1:0]  widx_q, widx_d;
    logic [NB_BIDX-1:0]  bidx_q, bidx_d;
    logic [LEN-1:0]      asm_q, asm_d;
    logic [NB_DIDX-1:0]  didx_q, didx_d;
    logic [LEN-1:0]      cyc_q, cyc_d;
    logic                prog_we_q, prog_we_d;
    logic [NB_PADDR-1:0] prog_addr_q, prog_addr_d;
    logic [LEN-1:0]      prog_data_q, prog_data_d;
    logic                cpu_en_q, cpu_en_d;
    logic                cpu_rst_n_q, cpu_rst_n_d;
    logic [NB_DADDR-1:0] dmem_addr_q, dmem_addr_d;

    logic                ser_load_c;
    logic                ser_send_c;
    logic [LEN-1:0]      ser_word_c;
    logic                ser_done_c;

    assign o_prog_we   = prog_we_q;
    assign o_prog_addr = prog_addr_q;
    assign o_prog_data = prog_data_q;
    assign o_cpu_en    = cpu_en_q;
    assign o_cpu_rst_n = cpu_rst_n_q;
    assign o_dmem_addr = dmem_addr_q;

    debug_word_serializer u_ser (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_load     (ser_load_c),
        .i_word     (ser_word_c),
        .i_send     (ser_send_c),
        .o_tx_data  (o_tx_data),
        .o_tx_start (o_tx_start),
        .o_done_c   (ser_done_c)
    );

    // Next-state and registered-output logic for command, load, run/step and dump.
    always_comb begin
        state_d     = state_q;
        nwords_d    = nwords_q;
        widx_d      = widx_q;
        bidx_d      = bidx_q;
        asm_d       = asm_q;
        didx_d      = didx_q;
        cyc_d       = cyc_q;
        prog_we_d   = 1'b0;
        prog_addr_d = prog_addr_q;
        prog_data_d = prog_data_q;
        cpu_en_d    = 1'b0;
        cpu_rst_n_d = cpu_rst_n_q;
        dmem_addr_d = dmem_addr_q;
        ser_load_c  = 1'b0;
        ser_send_c  = 1'b0;
        ser_word_c  = i_dmem_data;

        // Saturating count of cycles the core was allowed to advance.
        if (cpu_en_q && (cyc_q != '1)) begin
            cyc_d = cyc_q + LEN'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (i_rx_done) begin
                    case (i_rx_data)
                        CMD_LOAD: begin
                            state_d     = ST_LOAD_CNT;
                            cpu_rst_n_d = 1'b0;
                        end
                        CMD_CONT: state_d = ST_RUN;
                        CMD_STEP: begin
                            state_d  = ST_STEP;
                            cpu_en_d = !i_halt;
                        end
                        default: ;
                    endcase
                end
            end
            ST_LOAD_CNT: begin
                if (i_rx_done) begin
                    nwords_d = i_rx_data;
                    widx_d   = '0;
                    bidx_d   = '0;
                    if (i_rx_data == '0) begin
                        state_d     = ST_IDLE;
                        cpu_rst_n_d = 1'b1;
                        cyc_d       = '0;
                    end else begin
                        state_d = ST_LOAD_BYTE;
                    end
                end
            end
            ST_LOAD_BYTE: begin
                if (i_rx_done) begin
                    asm_d  = {asm_q[LEN-NB_BYTE-1:0], i_rx_data};
                    bidx_d = bidx_q + NB_BIDX'(1);
                    if (bidx_q == NB_BIDX'(BYTES_PER_WORD - 1)) begin
                        state_d = ST_LOAD_WR;
                        // Words past the end of program memory are swallowed.
                        if (widx_q < NB_WIDX'(RAM_DEPTH_PROGRAM)) begin
                            prog_we_d   = 1'b1;
                            prog_addr_d = NB_PADDR'(widx_q);
                            prog_data_d = asm_d;
                        end
                    end
                end
            end
            ST_LOAD_WR: begin
                widx_d = widx_q + NB_WIDX'(1);
                bidx_d = '0;
                if (widx_d == nwords_q) begin
                    state_d     = ST_IDLE;
                    cpu_rst_n_d = 1'b1;
                    cyc_d       = '0;
                end else begin
                    state_d = ST_LOAD_BYTE;
                end
            end
            ST_RUN: begin
                if (i_halt) begin
                    state_d     = ST_DUMP_LD;
                    didx_d      = '0;
                    dmem_addr_d = '0;
                end else begin
                    cpu_en_d = 1'b1;
                end
            end
            ST_STEP: begin
                state_d     = ST_DUMP_LD;
                didx_d      = '0;
                dmem_addr_d = '0;
            end
            ST_DUMP_LD: begin
                ser_load_c = 1'b1;
                if (didx_q == NB_DIDX'(0)) begin
                    ser_word_c = i_pc;
                end else if (didx_q == NB_DIDX'(1)) begin
                    ser_word_c = cyc_q;
                end
                state_d = ST_DUMP_TX;
            end
            ST_DUMP_TX: begin
                ser_send_c = 1'b1;
                state_d    = ST_DUMP_WAIT;
            end
            ST_DUMP_WAIT: begin
                if (i_tx_done) begin
                    if (!ser_done_c) begin
                        state_d = ST_DUMP_TX;
                    end else if (didx_q == NB_DIDX'(DUMP_WORDS - 1)) begin
                        state_d = ST_IDLE;
                    end else begin
                        didx_d  = didx_q + NB_DIDX'(1);
                        state_d = ST_DUMP_LD;
                        // Memory address leads the word latch by one cycle.
                        if (didx_q != NB_DIDX'(0)) begin
                            dmem_addr_d = NB_DADDR'(didx_q - NB_DIDX'(1));
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q     <= ST_IDLE;
            nwords_q    <= '0;
            widx_q      <= '0;
            bidx_q      <= '0;
            asm_q       <= '0;
            didx_q      <= '0;
            cyc_q       <= '0;
            prog_we_q   <= 1'b0;
            prog_addr_q <= '0;
            prog_data_q <= '0;
            cpu_en_q    <= 1'b0;
            cpu_rst_n_q <= 1'b1;
            dmem_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            nwords_q    <= nwords_d;
            widx_q      <= widx_d;
            bidx_q      <= bidx_d;
            asm_q       <= asm_d;
            didx_q      <= didx_d;
            cyc_q       <= cyc_d;
            prog_we_q   <= prog_we_d;
            prog_addr_q <= prog_addr_d;
            prog_data_q <= prog_data_d;
            cpu_en_q    <= cpu_en_d;
            cpu_rst_n_q <= cpu_rst_n_d;
            dmem_addr_q <= dmem_addr_d;
        end
    end

endmodule

// File: tb/tb_mips_debug_unit.sv
// Directed bench for mips_debug_unit: load, run, step and dump over the byte link.
module tb_mips_debug_unit;

    localparam int FRAME_BYTES = 136;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b0;
    logic [7:0]  i_rx_data = 8'h00;
    logic        i_rx_done = 1'b0;
    logic        i_tx_done = 1'b0;
    logic        i_halt = 1'b0;
    logic [31:0] i_pc = 32'h0;
    logic [31:0] i_dmem_data;
    logic [7:0]  o_tx_data;
    logic        o_tx_start;
    logic        o_prog_we;
    logic [4:0]  o_prog_addr;
    logic [31:0] o_prog_data;
    logic        o_cpu_en;
    logic        o_cpu_rst_n;
    logic [4:0]  o_dmem_addr;

    int n_checks = 0;
    int n_errors = 0;

    // Observers updated on every active edge (values sampled before the edge).
    int          n_writes = 0;
    int          n_we_rst = 0;
    int          en_cycles = 0;
    int          n_rst_low = 0;
    logic [4:0]  last_addr = 5'd0;
    logic [31:0] last_data = 32'h0;
    logic [31:0] prog_mem [0:31];

    logic [7:0]  frame [0:FRAME_BYTES-1];
    int          frame_len;

    logic [7:0]  ld_bytes [0:7] = '{8'h20, 8'h01, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h0C};

    always #5 i_clk = ~i_clk;

    // Data memory stand-in: distinct, address-dependent word per location.
    function automatic logic [31:0] dmem_word(input logic [4:0] a);
        return {8'hDA, 3'b000, a, 8'h5A, 3'b000, a};
    endfunction

    assign i_dmem_data = dmem_word(o_dmem_addr);

    mips_debug_unit dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_rx_data   (i_rx_data),
        .i_rx_done   (i_rx_done),
        .o_tx_data   (o_tx_data),
        .o_tx_start  (o_tx_start),
        .i_tx_done   (i_tx_done),
        .o_prog_we   (o_prog_we),
        .o_prog_addr (o_prog_addr),
        .o_prog_data (o_prog_data),
        .o_cpu_en    (o_cpu_en),
        .o_cpu_rst_n (o_cpu_rst_n),
        .i_halt      (i_halt),
        .i_pc        (i_pc),
        .o_dmem_addr (o_dmem_addr),
        .i_dmem_data (i_dmem_data)
    );

    always @(posedge i_clk) begin
        if (o_cpu_en) en_cycles++;
        if (!o_cpu_rst_n) n_rst_low++;
        if (o_prog_we) begin
            prog_mem[o_prog_addr] = o_prog_data;
            n_writes++;
            if (!o_cpu_rst_n) n_we_rst++;
            last_addr = o_prog_addr;
            last_data = o_prog_data;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_outputs();
        check_eq("rst_tx_start",  o_tx_start,  0);
        check_eq("rst_tx_data",   o_tx_data,   0);
        check_eq("rst_prog_we",   o_prog_we,   0);
        check_eq("rst_prog_addr", o_prog_addr, 0);
        check_eq("rst_prog_data", o_prog_data, 0);
        check_eq("rst_cpu_en",    o_cpu_en,    0);
        check_eq("rst_cpu_rst_n", o_cpu_rst_n, 1);
        check_eq("rst_dmem_addr", o_dmem_addr, 0);
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge i_clk);
        i_rx_data = b;
        i_rx_done = 1'b1;
        @(negedge i_clk);
        i_rx_done = 1'b0;
    endtask

    task automatic send_gap(input logic [7:0] b);
        send_byte(b);
        repeat (2) @(negedge i_clk);
    endtask

    task automatic send_word(input logic [31:0] w);
        send_gap(w[31:24]);
        send_gap(w[23:16]);
        send_gap(w[15:8]);
        send_gap(w[7:0]);
    endtask

    // Act as the UART transmitter; optionally inject an 'L' while a byte is in flight.
    task automatic recv_frame(input int inject_idx);
        int  early;
        int  extra;
        bit  got;
        early = 0;
        extra = 0;
        frame_len = 0;
        for (int i = 0; i < FRAME_BYTES; i++) frame[i] = 8'h00;
        for (int b = 0; b < FRAME_BYTES; b++) begin
            got = 1'b0;
            for (int c = 0; c < 64 && !got; c++) begin
                @(negedge i_clk);
                if (o_tx_start) begin
                    got = 1'b1;
                    frame[b] = o_tx_data;
                end
            end
            if (!got) break;
            frame_len++;
            for (int c = 0; c < 4; c++) begin
                @(negedge i_clk);
                if (b == inject_idx && c == 1) begin
                    i_rx_data = 8'h4C;
                    i_rx_done = 1'b1;
                end else begin
                    i_rx_done = 1'b0;
                end
                if (o_tx_start) early++;
            end
            i_rx_done = 1'b0;
            i_tx_done = 1'b1;
            @(negedge i_clk);
            i_tx_done = 1'b0;
        end
        repeat (20) begin
            @(negedge i_clk);
            if (o_tx_start) extra++;
        end
        check_eq("frame_len", frame_len, FRAME_BYTES);
        check_eq("start_before_done", early, 0);
        check_eq("start_after_frame", extra, 0);
    endtask

    function automatic logic [31:0] word_at(input int idx);
        return {frame[4*idx], frame[4*idx+1], frame[4*idx+2], frame[4*idx+3]};
    endfunction

    task automatic check_frame(input logic [31:0] exp_pc, input logic [31:0] exp_cnt);
        int bad;
        bad = 0;
        check_eq("frame_pc", word_at(0), exp_pc);
        check_eq("frame_cycles", word_at(1), exp_cnt);
        for (int w = 0; w < 32; w++) begin
            if (word_at(w + 2) !== dmem_word(5'(w))) bad++;
        end
        check_eq("frame_dmem_bad_words", bad, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int en0;
        int w0;
        int r0;
        int rl0;

        // Power-on reset.
        repeat (3) @(negedge i_clk);
        check_reset_outputs();
        i_rst = 1'b1;
        @(negedge i_clk);

        // Reset while the core is running.
        i_halt = 1'b0;
        i_pc   = 32'h28;
        send_byte(8'h43);
        repeat (5) @(negedge i_clk);
        check_eq("run_en_before_reset", o_cpu_en, 1);
        #2 i_rst = 1'b0;
        #1 check_reset_outputs();
        @(negedge i_clk);
        i_rst = 1'b1;
        en0 = en_cycles;
        repeat (5) @(negedge i_clk);
        check_eq("en_after_reset", o_cpu_en, 0);
        check_eq("en_cycles_after_reset", en_cycles - en0, 0);

        // Two-word program load.
        w0 = n_writes;
        r0 = n_we_rst;
        send_gap(8'h4C);
        check_eq("load_cpu_rst_low", o_cpu_rst_n, 0);
        send_gap(8'h02);
        for (int i = 0; i < 8; i++) send_gap(ld_bytes[i]);
        check_eq("load_writes", n_writes - w0, 2);
        check_eq("load_we_in_reset", n_we_rst - r0, 2);
        check_eq("load_word0", prog_mem[0], 32'h20010005);
        check_eq("load_word1", prog_mem[1], 32'h0000000C);
        check_eq("load_cpu_rst_release", o_cpu_rst_n, 1);

        // Overflowing load: 33 words into a 32-word memory.
        w0 = n_writes;
        send_gap(8'h4C);
        send_gap(8'd33);
        for (int w = 0; w < 33; w++) send_word(32'h10000000 + 32'(w));
        check_eq("ovf_writes", n_writes - w0, 32);
        check_eq("ovf_last_addr", last_addr, 31);
        check_eq("ovf_last_data", last_data, 32'h1000001F);
        check_eq("ovf_word0_kept", prog_mem[0], 32'h10000000);
        check_eq("ovf_cpu_rst_release", o_cpu_rst_n, 1);

        // Continuous run halting after 10 enabled cycles, 'L' injected mid-dump.
        i_pc   = 32'h28;
        i_halt = 1'b0;
        en0 = en_cycles;
        w0  = n_writes;
        rl0 = n_rst_low;
        send_byte(8'h43);
        for (int c = 0; c < 200; c++) begin
            if (en_cycles == en0 + 9 && o_cpu_en) begin
                i_halt = 1'b1;
                break;
            end
            @(negedge i_clk);
        end
        recv_frame(20);
        check_eq("cont_en_cycles", en_cycles - en0, 10);
        check_frame(32'h28, 32'd10);
        check_eq("dump_load_ignored_rst", n_rst_low - rl0, 0);
        check_eq("dump_load_ignored_we", n_writes - w0, 0);
        check_eq("post_dump_cpu_rst_n", o_cpu_rst_n, 1);

        // Single steps from a cleared counter.
        @(negedge i_clk);
        i_rst = 1'b0;
        @(negedge i_clk);
        i_rst  = 1'b1;
        i_halt = 1'b0;
        i_pc   = 32'h44;
        for (int s = 1; s <= 2; s++) begin
            en0 = en_cycles;
            send_byte(8'h53);
            recv_frame(-1);
            check_eq("step_en_cycles", en_cycles - en0, 1);
            check_frame(32'h44, 32'(s));
        end

        // Step while halted: no enable cycle, counter unchanged.
        i_halt = 1'b1;
        en0 = en_cycles;
        send_byte(8'h53);
        recv_frame(-1);
        check_eq("step_halted_en_cycles", en_cycles - en0, 0);
        check_frame(32'h44, 32'd2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mips_debug_unit.md
Name: mips_debug_unit

Overview:
- Host-side controller sequencing the pipelined MIPS core over a byte link (UART rx/tx wrappers external).
- Loads program memory, gates the core's clock-enable (continuous run or single step), then dumps PC, cycle count and data memory back to the host.
- Sits in the top level between the UART and the core/memories; the core only advances while o_cpu_en=1.

Parameters:
LEN, 32, datapath/word width (bits)
NB_BYTE, 8, link byte width
RAM_DEPTH_PROGRAM, 32, program memory depth (words)
RAM_DEPTH_DATA, 32, data memory depth (words)
NB_PADDR, 5, program memory address width (clog2 RAM_DEPTH_PROGRAM)
NB_DADDR, 5, data memory debug-read address width (clog2 RAM_DEPTH_DATA)

Ports:
i_clk  in  1  system clock
i_rst  in  1  asynchronous active-low reset
i_rx_data  in  NB_BYTE  received byte
i_rx_done  in  1  one-cycle strobe, i_rx_data valid
o_tx_data  out  NB_BYTE  byte to transmit
o_tx_start  out  1  one-cycle strobe, start transmission
i_tx_done  in  1  one-cycle strobe, byte sent
o_prog_we  out  1  program memory write enable
o_prog_addr  out  NB_PADDR  program memory write address (word)
o_prog_data  out  LEN  program memory write data
o_cpu_en  out  1  core pipeline clock-enable
o_cpu_rst_n  out  1  core reset (active-low), low while loading
i_halt  in  1  HALT instruction reached WB
i_pc  in  LEN  core PC
o_dmem_addr  out  NB_DADDR  data memory debug read address
i_dmem_data  in  LEN  data memory debug read data (combinational, same cycle)

Behaviour:
- Reset (i_rst=0, async): state IDLE; o_tx_start=0, o_prog_we=0, o_prog_addr=0, o_prog_data=0, o_cpu_en=0, o_cpu_rst_n=1, o_dmem_addr=0, o_tx_data=0; cycle counter=0, step flag=0. Reset mid-load/run/dump aborts immediately; partial program words already written stay in memory.
- Commands (accepted only in IDLE; other bytes in IDLE ignored): 0x4C 'L' load, 0x43 'C' continuous, 0x53 'S' step.
- Bytes arriving outside IDLE/LOAD_CNT/LOAD_BYTE are ignored (not queued).
- FSM: IDLE, LOAD_CNT, LOAD_BYTE, LOAD_WR, RUN, STEP, DUMP_LD, DUMP_TX, DUMP_WAIT.
- 'L' -> LOAD_CNT: o_cpu_rst_n=0 from entry until return to IDLE. Next byte = word count N. N=0 -> IDLE.
- LOAD_BYTE: assembles 4 bytes MSB-first into a word. After the 4th byte -> LOAD_WR: o_prog_we=1 for exactly 1 cycle, addr = word index, data = word.
- Word index >= RAM_DEPTH_PROGRAM: word consumed, o_prog_we stays 0.
- After N words -> IDLE; cycle counter cleared to 0.
- 'C' -> RUN: o_cpu_en=1 each cycle until i_halt sampled 1. o_cpu_en drops the cycle after i_halt is seen, then -> DUMP_LD. If i_halt already 1 on entry, zero enabled cycles, straight to DUMP_LD.
- 'S' -> STEP: o_cpu_en=1 for exactly one cycle (suppressed if i_halt=1), then DUMP_LD.
- Cycle counter: +1 per o_cpu_en=1 cycle, saturates at 2^LEN-1.
- Dump frame, each word MSB byte first: PC (4 bytes), cycle count (4 bytes), then data memory words 0..RAM_DEPTH_DATA-1. Total 8+4*RAM_DEPTH_DATA bytes (136 at defaults).
- Dump snapshots i_pc and the counter in DUMP_LD; memory words are latched from i_dmem_data with o_dmem_addr set one cycle earlier.
- TX handshake: DUMP_TX drives o_tx_data and pulses o_tx_start for 1 cycle. DUMP_WAIT holds until i_tx_done, then issues the next byte. After the last byte -> IDLE.
- i_tx_done outside DUMP_WAIT is ignored.

Decomposition:
- Shared package (mips_pkg): command opcodes 0x4C/0x43/0x53, FSM state encoding, NB_BYTE, bytes-per-word = LEN/NB_BYTE.
- One natural sub-module, debug_word_serializer: loads a LEN-bit word and emits it MSB-first byte-by-byte with the tx start/done handshake. It is used for the PC, the counter and memory words.

Test Plan:
- Reset mid-RUN (o_cpu_en=1, i_rst=0) -> all outputs at reset values immediately; after release, state IDLE, o_cpu_en=0.
- Load: 0x4C,0x02, bytes 20 01 00 05, 00 00 00 0C -> o_prog_we pulses twice: addr0=0x20010005, addr1=0x0000000C; o_cpu_rst_n=0 throughout, 1 after.
- Load overflow: N=33 -> 32 writes (addr 0..31), 33rd word consumed with no write, FSM back in IDLE.
- Continuous: 'C', i_halt asserted after 10 enabled cycles, i_pc=0x28 -> exactly 10 cycles of o_cpu_en=1. Frame starts 00 00 00 28 00 00 00 0A, 136 bytes total; each o_tx_start waits for the prior i_tx_done.
- Step twice: 'S', dump, 'S', dump -> one o_cpu_en cycle per step; counter fields read 1 then 2. Step with i_halt=1 -> no enable cycle, counter unchanged.
- Bytes 0x4C received during DUMP_WAIT -> ignored: no load entered, frame continues uninterrupted.
